video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync, back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync, back porch in lines.
REQ-005 Parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-006 Port clk, input, 1: pixel-domain clock; the only clock.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port en, input, 1: pixel tick; all state advances only on cycles with en=1.
REQ-009 Port DE, output, 1: data enable, high inside the active area.
REQ-010 Port hdmi_h_sync / hdmi_v_sync, output, 1 each: horizontal / vertical sync at SYNC_POL.
REQ-011 Port x_pixel / y_pixel, output, 11 each: current horizontal / vertical counter value.
REQ-012 Port line_start / frame_start, output, 1 each: single-cycle pulses at x=0 / at x=0,y=0.

Function
REQ-013 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP shall each be <= 2048; otherwise elaboration fails.
REQ-014 h_cnt shall count 0..H_TOTAL-1 on en cycles and wrap to 0; v_cnt shall increment only when h_cnt wraps, and shall wrap to 0 after V_TOTAL-1.
REQ-015 Each axis shall keep a region FSM {ACTIVE, FRONT, SYNC, BACK}, advancing ACTIVE->FRONT->SYNC->BACK->ACTIVE when that axis counter crosses the region boundary; no other transitions.
REQ-016 All outputs shall be registered; on an en cycle they load the decode of the counters' current values, so outputs lag the counters by exactly one en cycle.
REQ-017 Decode: DE=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-018 Decode: hdmi_h_sync=SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
REQ-019 Decode: hdmi_v_sync=SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking.
REQ-020 Decode: x_pixel=h_cnt and y_pixel=v_cnt, zero-extended to 11 bits, valid in blanking too.
REQ-021 Decode: line_start=1 iff h_cnt=0; frame_start=1 iff h_cnt=0 and v_cnt=0.
REQ-022 On en=0 cycles, counters, FSMs, DE, syncs and x/y shall hold, and line_start/frame_start shall load 0, so each pulse lasts exactly one clk.
REQ-023 At the simultaneous wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), both counters shall return to 0 on the same en cycle.

Reset
REQ-024 While reset=0: h_cnt=0, v_cnt=0, both FSMs=ACTIVE, DE=0, syncs=~SYNC_POL, x_pixel=0, y_pixel=0, line_start=0, frame_start=0.
REQ-025 Reset assertion mid-frame shall take effect immediately without waiting for clk.
REQ-026 First en cycle after release shall output DE=1, x=0, y=0, line_start=1, frame_start=1.

Structure
REQ-027 Package video_timing_pkg shall hold the region enum type and the default 640x480 timing constants.
REQ-028 Sub-module axis_counter, holding one counter plus region FSM with an advance input and a wrap output, shall be instantiated once per axis.

Verification
REQ-029 Defaults, en=1 continuously: DE high 640 cycles per line, 307200 per frame; frame_start period 420000 clk.
REQ-030 Defaults: hdmi_h_sync low for exactly x=656..751 (96 clk); hdmi_v_sync low for exactly y=490..491 (1600 clk).
REQ-031 H=4/1/1/1, V=2/1/1/1, en toggling 1,0 each cycle: same output sequence as en=1, each value held 2 clk; line_start pulses 1 clk.
REQ-032 reset=0 asserted asynchronously at x=300,y=200: outputs take reset values before next clk edge; first en after release gives frame_start=1, x=0, y=0.
REQ-033 SYNC_POL=1: sync polarity inverted in all regions and in reset (syncs=0 during reset).
REQ-034 Wrap: output x=799,y=524 is followed on the next en cycle by x=0,y=0, frame_start=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the video timing generator.
package video_timing_pkg;

  // Per-axis region; order matches the scan order within a line or frame.
  typedef enum logic [1:0] {
    RegActive,
    RegFront,
    RegSync,
    RegBack
  } region_e;

  // Counter and coordinate width; totals up to 2048 fit.
  localparam int unsigned CntW     = 11;
  localparam int unsigned MaxTotal = 2048;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;

  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One timing axis: a wrapping counter plus the region FSM that tracks it.
module axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DefHActive,
  parameter int unsigned FP     = DefHFp,
  parameter int unsigned SYNC   = DefHSync,
  parameter int unsigned BP     = DefHBp
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_adv,
  output logic [CntW-1:0] o_cnt,
  output region_e         o_region,
  output logic            o_wrap
);

  localparam int unsigned Total = ACTIVE + FP + SYNC + BP;

  if (Total > MaxTotal) begin : g_total_chk
    $error("axis_counter: total of %0d exceeds %0d", Total, MaxTotal);
  end
  // An empty segment would need a region transition the FSM does not have.
  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_seg_chk
    $error("axis_counter: every segment must be at least one unit long");
  end

  localparam logic [CntW-1:0] LastCnt    = CntW'(Total - 1);
  localparam logic [CntW-1:0] FrontStart = CntW'(ACTIVE);
  localparam logic [CntW-1:0] SyncStart  = CntW'(ACTIVE + FP);
  localparam logic [CntW-1:0] BackStart  = CntW'(ACTIVE + FP + SYNC);

  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  region_e         r_region, w_region_nxt;

  assign o_wrap   = (r_cnt == LastCnt);
  assign o_cnt    = r_cnt;
  assign o_region = r_region;

  // Next count and region; the region follows the count across each boundary.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_region_nxt = r_region;
    if (i_adv) begin
      w_cnt_nxt = o_wrap ? '0 : r_cnt + 1'b1;
      unique case (r_region)
        RegActive: if (w_cnt_nxt == FrontStart) w_region_nxt = RegFront;
        RegFront:  if (w_cnt_nxt == SyncStart)  w_region_nxt = RegSync;
        RegSync:   if (w_cnt_nxt == BackStart)  w_region_nxt = RegBack;
        RegBack:   if (o_wrap)                  w_region_nxt = RegActive;
        default:   w_region_nxt = RegActive;
      endcase
    end
  end

  // Counter and region state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_region <= RegActive;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_region <= w_region_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: two axis counters and a registered output decode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            DE,
  output logic            hdmi_h_sync,
  output logic            hdmi_v_sync,
  output logic [CntW-1:0] x_pixel,
  output logic [CntW-1:0] y_pixel,
  output logic            line_start,
  output logic            frame_start
);

  logic [CntW-1:0] w_h_cnt, w_v_cnt;
  region_e         w_h_region, w_v_region;
  logic            w_h_wrap;
  logic            w_v_adv;

  // The vertical axis steps once per completed line.
  assign w_v_adv = en & w_h_wrap;

  axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (en),
    .o_cnt   (w_h_cnt),
    .o_region(w_h_region),
    .o_wrap  (w_h_wrap)
  );

  axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_v_adv),
    .o_cnt   (w_v_cnt),
    .o_region(w_v_region),
    .o_wrap  ()
  );

  logic            r_de, r_hs, r_vs, r_ls, r_fs;
  logic [CntW-1:0] r_x, r_y;

  // Registered decode of the current counters; pulses clear on idle ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_de <= 1'b0;
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
      r_x  <= '0;
      r_y  <= '0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (en) begin
      r_de <= (w_h_region == RegActive) && (w_v_region == RegActive);
      r_hs <= (w_h_region == RegSync) ? SYNC_POL : ~SYNC_POL;
      r_vs <= (w_v_region == RegSync) ? SYNC_POL : ~SYNC_POL;
      r_x  <= w_h_cnt;
      r_y  <= w_v_cnt;
      r_ls <= (w_h_cnt == '0);
      r_fs <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign DE          = r_de;
  assign hdmi_h_sync = r_hs;
  assign hdmi_v_sync = r_vs;
  assign x_pixel     = r_x;
  assign y_pixel     = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench: default 640x480 timing plus a tiny 7x5 frame
// in both sync polarities.
module tb_video_timing_gen;

  logic clk;
  logic rst_n;
  logic en_d, en_s;

  logic        d_de, d_hs, d_vs, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic        s_de, s_hs, s_vs, s_ls, s_fs;
  logic [10:0] s_x, s_y;
  logic        p_de, p_hs, p_vs, p_ls, p_fs;
  logic [10:0] p_x, p_y;

  int n_tests = 0;
  int n_fail  = 0;

  video_timing_gen u_dflt (
    .clk(clk), .reset(rst_n), .en(en_d),
    .DE(d_de), .hdmi_h_sync(d_hs), .hdmi_v_sync(d_vs),
    .x_pixel(d_x), .y_pixel(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(rst_n), .en(en_s),
    .DE(s_de), .hdmi_h_sync(s_hs), .hdmi_v_sync(s_vs),
    .x_pixel(s_x), .y_pixel(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset(rst_n), .en(en_s),
    .DE(p_de), .hdmi_h_sync(p_hs), .hdmi_v_sync(p_vs),
    .x_pixel(p_x), .y_pixel(p_y), .line_start(p_ls), .frame_start(p_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ex, ey, xp, yp, dep;
    int de0, de1, hs_lo, hs_first, hs_last, ls_cnt;

    rst_n = 1'b0;
    en_d  = 1'b0;
    en_s  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, both polarities.
    chk("rst_d_de", d_de, 0);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_x", d_x, 0);
    chk("rst_d_y", d_y, 0);
    chk("rst_d_ls", d_ls, 0);
    chk("rst_d_fs", d_fs, 0);
    chk("rst_p_hs", p_hs, 0);
    chk("rst_p_vs", p_vs, 0);
    chk("rst_p_de", p_de, 0);

    // Tiny frame (7x5), en toggling 1,0; each en cycle k shows count k.
    rst_n = 1'b1;
    for (int k = 0; k < 41; k++) begin
      en_s = 1'b1;
      @(posedge clk);
      #1;
      ex = k % 7;
      ey = (k / 7) % 5;
      chk("sm_x", s_x, ex);
      chk("sm_y", s_y, ey);
      chk("sm_de", s_de, (ex < 4 && ey < 2) ? 1 : 0);
      chk("sm_hs", s_hs, (ex == 5) ? 0 : 1);
      chk("sm_vs", s_vs, (ey == 3) ? 0 : 1);
      chk("sm_ls", s_ls, (ex == 0) ? 1 : 0);
      chk("sm_fs", s_fs, (ex == 0 && ey == 0) ? 1 : 0);
      chk("pol_hs", p_hs, (ex == 5) ? 1 : 0);
      chk("pol_vs", p_vs, (ey == 3) ? 1 : 0);
      if (k == 35) begin
        chk("wrap_fs", s_fs, 1);
        chk("wrap_x", s_x, 0);
        chk("wrap_y", s_y, 0);
      end
      xp  = ex;
      yp  = ey;
      dep = (ex < 4 && ey < 2) ? 1 : 0;
      en_s = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_x", s_x, xp);
      chk("hold_y", s_y, yp);
      chk("hold_de", s_de, dep);
      chk("hold_ls", s_ls, 0);
      chk("hold_fs", s_fs, 0);
    end

    // Asynchronous reset mid-frame on the tiny frame (x=6,y=0 is showing).
    en_s = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_arst_x", s_x, 6);
    en_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sm_x", s_x, 0);
    chk("arst_sm_de", s_de, 0);
    chk("arst_sm_hs", s_hs, 1);
    chk("arst_pol_hs", p_hs, 0);
    repeat (2) @(posedge clk);
    #1;

    // Default timing, en held high for just over two lines.
    rst_n = 1'b1;
    en_d  = 1'b1;
    en_s  = 1'b1;
    de0 = 0; de1 = 0; hs_lo = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int k = 0; k < 1900; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk("sm_rel_fs", s_fs, 1);
        chk("sm_rel_x", s_x, 0);
        chk("sm_rel_y", s_y, 0);
        chk("d_first_de", d_de, 1);
        chk("d_first_fs", d_fs, 1);
        en_s = 1'b0;
      end
      if (d_ls) ls_cnt++;
      if (k < 800) begin
        if (d_de) de0++;
        if (!d_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
      end else if (k < 1600) begin
        if (d_de) de1++;
      end
      if (k == 799) begin
        chk("d_eol_x", d_x, 799);
        chk("d_eol_y", d_y, 0);
        chk("d_eol_vs", d_vs, 1);
      end
      if (k == 800) begin
        chk("d_l1_x", d_x, 0);
        chk("d_l1_y", d_y, 1);
        chk("d_l1_ls", d_ls, 1);
        chk("d_l1_fs", d_fs, 0);
      end
    end
    chk("d_de_line0", de0, 640);
    chk("d_de_line1", de1, 640);
    chk("d_hs_len", hs_lo, 96);
    chk("d_hs_first", hs_first, 656);
    chk("d_hs_last", hs_last, 751);
    chk("d_ls_count", ls_cnt, 3);
    chk("d_mid_x", d_x, 299);
    chk("d_mid_y", d_y, 2);

    // Asynchronous reset mid-line on the default timing.
    #2 rst_n = 1'b0;
    #1;
    chk("d_arst_x", d_x, 0);
    chk("d_arst_y", d_y, 0);
    chk("d_arst_de", d_de, 0);
    chk("d_arst_hs", d_hs, 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("d_rel_fs", d_fs, 1);
    chk("d_rel_ls", d_ls, 1);
    chk("d_rel_x", d_x, 0);
    chk("d_rel_y", d_y, 0);
    chk("d_rel_de", d_de, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
